rd_writeback: RTL

Writeback stage of the RV32I core and the consumer of the 2-bit `rd_sel` writeback-source code produced by the control unit. It accepts one retiring instruction per handshake, selects the destination value (load data, immediate, ALU result or PC+4), and, for loads, waits for the data-memory response and size/sign-extends it. It then issues a single-cycle register-file write.

---
 rtl/rd_writeback_if.sv | 38 +++
 rtl/rd_writeback.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_writeback_if.sv
// Issue bus from the execute stage into the writeback stage.
// The execute stage is the master (it presents an instruction); writeback
// is the slave (it returns in_ready). Transfer happens on in_valid & in_ready.
interface rd_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  rd_sel;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [2:0]  funct3;

    modport master (
        output in_valid,
        output rd_sel,
        output rd_we,
        output rd_addr,
        output alu_result,
        output imm,
        output pc_plus4,
        output funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  rd_sel,
        input  rd_we,
        input  rd_addr,
        input  alu_result,
        input  imm,
        input  pc_plus4,
        input  funct3,
        output in_ready
    );
endinterface

// File: rtl/rd_writeback.sv
// Writeback stage of the RV32I core.
// Accepts one retiring instruction per handshake, picks the destination value
// (load data, immediate, ALU result or PC+4) from the 2-bit rd_sel code, waits
// for the data-memory response on loads, size/sign-extends it and issues a
// single-cycle register-file write. Writes to x0 are suppressed.
//
// Optional feature: define RD_WRITEBACK_LOAD_TIMEOUT_EN to bound the time
// spent waiting for a load response to TIMEOUT_CYCLES cycles; on expiry the
// load is dropped and load_err pulses for one cycle. Without the macro the
// stage waits indefinitely and load_err is tied low.
module rd_writeback #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rd_writeback_if.slave        in_if,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 busy,
    output logic                 load_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_IMM  = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_PC4  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [7:0] TIMEOUT_LIM_C = 8'(TIMEOUT_CYCLES);

    // Reject an out-of-range timeout at elaboration time.
    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
        $error("rd_writeback: TIMEOUT_CYCLES must be in 1..255");
    end

    // Extract the addressed byte/halfword from the aligned read word and
    // extend it according to the load width/sign code. Unknown codes return
    // the full word.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  res_v = {24'd0, byte_v};
            F3_LH:   res_v = {{16{half_v[15]}}, half_v};
            F3_LHU:  res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    // Non-load writeback source selection.
    function automatic logic [31:0] select_operand(
        input logic [1:0]  sel,
        input logic [31:0] imm_v,
        input logic [31:0] alu_v,
        input logic [31:0] pc4_v
    );
        logic [31:0] res_v;
        case (sel)
            SEL_IMM: res_v = imm_v;
            SEL_ALU: res_v = alu_v;
            SEL_PC4: res_v = pc4_v;
            default: res_v = 32'd0;
        endcase
        return res_v;
    endfunction

    state_t      state_r;
    state_t      next_state_s;

    logic [4:0]  cap_addr_r;
    logic [2:0]  cap_funct3_r;
    logic [1:0]  cap_off_r;

    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] rf_wdata_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        wr_en_s;
    logic        wr_upd_s;
    logic [4:0]  wr_addr_s;
    logic [31:0] wr_data_s;

`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
    logic [7:0]  cnt_r;
    logic        cnt_clr_s;
    logic        cnt_inc_s;
    logic        timeout_s;
    logic        err_set_s;
    logic        load_err_r;
`endif

    assign in_ready_s     = (state_r == ST_IDLE) | (state_r == ST_WRITE);
    assign accept_s       = in_if.in_valid & in_ready_s;
    assign in_if.in_ready = in_ready_s;
    assign busy           = (state_r == ST_WAIT_MEM);

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
    // The wait expires on the cycle whose count would reach the limit.
    assign timeout_s = ((cnt_r + 8'd1) == TIMEOUT_LIM_C);
    assign load_err  = load_err_r;
`else
    assign load_err  = 1'b0;
`endif

    // Next-state decode and write request generation.
    always_comb begin
        next_state_s = ST_IDLE;
        wr_en_s      = 1'b0;
        wr_upd_s     = 1'b0;
        wr_addr_s    = rf_waddr_r;
        wr_data_s    = rf_wdata_r;
`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        err_set_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_WRITE: begin
                if (accept_s) begin
                    if (!in_if.rd_we) begin
                        next_state_s = ST_IDLE;
                    end else if (in_if.rd_sel == SEL_LOAD) begin
                        next_state_s = ST_WAIT_MEM;
`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
                        cnt_clr_s    = 1'b1;
`endif
                    end else begin
                        next_state_s = ST_WRITE;
                        wr_upd_s     = 1'b1;
                        wr_en_s      = (in_if.rd_addr != 5'd0);
                        wr_addr_s    = in_if.rd_addr;
                        wr_data_s    = select_operand(in_if.rd_sel, in_if.imm,
                                                      in_if.alu_result, in_if.pc_plus4);
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    next_state_s = ST_WRITE;
                    wr_upd_s     = 1'b1;
                    wr_en_s      = (cap_addr_r != 5'd0);
                    wr_addr_s    = cap_addr_r;
                    wr_data_s    = load_extract(cap_funct3_r, cap_off_r, mem_rdata);
                end else begin
`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
                    if (timeout_s) begin
                        next_state_s = ST_IDLE;
                        err_set_s    = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT_MEM;
                        cnt_inc_s    = 1'b1;
                    end
`else
                    next_state_s = ST_WAIT_MEM;
`endif
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the fields a pending load needs once the response arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr_r   <= 5'd0;
            cap_funct3_r <= 3'd0;
            cap_off_r    <= 2'd0;
        end else if (accept_s) begin
            cap_addr_r   <= in_if.rd_addr;
            cap_funct3_r <= in_if.funct3;
            cap_off_r    <= in_if.alu_result[1:0];
        end
    end

    // Registered register-file write port; address/data hold outside WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else begin
            rf_we_r <= wr_en_s;
            if (wr_upd_s) begin
                rf_waddr_r <= wr_addr_s;
                rf_wdata_r <= wr_data_s;
            end
        end
    end

`ifdef RD_WRITEBACK_LOAD_TIMEOUT_EN
    // Load-response wait counter: cleared on WAIT_MEM entry, counts idle waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (cnt_clr_s) begin
            cnt_r <= 8'd0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // One-cycle load timeout error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= err_set_s;
        end
    end
`endif

endmodule
